// File: rtl/merge_pi.sv
// Two-stream merger: a small FIFO per input, then round-robin arbitration onto
// one registered output that carries a source tag and a transfer count.
module merge_pi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra wrap bit separates full from empty when the low bits match.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module merge_pi #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     flow_in_a,
  input  logic                 flow_in_a_valid,
  output logic                 flow_in_a_ready,
  input  logic [WIDTH-1:0]     flow_in_b,
  input  logic                 flow_in_b_valid,
  output logic                 flow_in_b_ready,
  output logic [WIDTH-1:0]     flow_out,
  output logic                 flow_out_valid,
  input  logic                 flow_out_ready,
  output logic                 flow_out_src,
  output logic [CNT_WIDTH-1:0] merge_count
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][WIDTH-1:0] in_data, head;
  logic [NUM_SRC-1:0]            in_valid, push, pop, full, empty;
  logic                          last_grant, grant_b, load, do_load;

  assign in_data  = {flow_in_b, flow_in_a};
  assign in_valid = {flow_in_b_valid, flow_in_a_valid};

  // Ready comes from registered occupancy only, so a full FIFO stays closed
  // in the cycle it is popped.
  assign flow_in_a_ready = !full[0];
  assign flow_in_b_ready = !full[1];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign push[s] = in_valid[s] && !full[s];
    merge_pi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[s]),
      .din   (in_data[s]),
      .pop   (pop[s]),
      .full  (full[s]),
      .empty (empty[s]),
      .head  (head[s])
    );
  end

  // Under contention the source that did not win last time is served.
  always_comb begin
    grant_b = 1'b0;
    if (!empty[0] && !empty[1]) grant_b = !last_grant;
    else if (!empty[1])         grant_b = 1'b1;
  end

  assign load    = !flow_out_valid || flow_out_ready;
  assign do_load = load && (!empty[0] || !empty[1]);
  assign pop     = {do_load && grant_b, do_load && !grant_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flow_out       <= '0;
      flow_out_src   <= 1'b0;
      flow_out_valid <= 1'b0;
      last_grant     <= 1'b1;
      merge_count    <= '0;
    end else begin
      if (do_load) begin
        flow_out       <= grant_b ? head[1] : head[0];
        flow_out_src   <= grant_b;
        flow_out_valid <= 1'b1;
        last_grant     <= grant_b;
      end else if (flow_out_valid && flow_out_ready) begin
        flow_out_valid <= 1'b0;
      end
      if (flow_out_valid && flow_out_ready)
        merge_count <= merge_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/merge_pi.md
Name: merge_pi

Overview:
- Two-stream-to-one merger, the converging counterpart to the branching flow blocks.
- Accepts two independent valid/ready input flows, buffers each in a small FIFO, and round-robin arbitrates them onto one registered output flow.
- Tags every output word with its source and keeps a transfer count.
- Sits where split flow paths rejoin before a single downstream consumer.

Parameters:
- WIDTH, 32, data width of every flow word.
- DEPTH, 4, entries per input FIFO; power of two, minimum 2.
- CNT_WIDTH, 16, width of the output transfer counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flow_in_a  input  WIDTH  stream A data.
- flow_in_a_valid  input  1  stream A word present.
- flow_in_a_ready  output  1  stream A FIFO can accept.
- flow_in_b  input  WIDTH  stream B data.
- flow_in_b_valid  input  1  stream B word present.
- flow_in_b_ready  output  1  stream B FIFO can accept.
- flow_out  output  WIDTH  merged data.
- flow_out_valid  output  1  merged word present.
- flow_out_ready  input  1  downstream accepts.
- flow_out_src  output  1  source of flow_out: 0 = A, 1 = B.
- merge_count  output  CNT_WIDTH  completed output transfers.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async assert, sync deassert assumed upstream):
  - both FIFOs empty, pointers 0;
  - flow_out_valid = 0, flow_out = 0, flow_out_src = 0;
  - merge_count = 0;
  - last_grant = B, so A wins the first contention.
- Input handshake:
  - transfer on an edge with valid && ready;
  - flow_in_x_ready = !full_x, from registered occupancy only; no combinational path from flow_out_ready.
  - A full FIFO deasserts ready even if it is popped in the same cycle (no pass-through); ready rises the cycle after the pop.
- FIFOs: DEPTH entries each, log2(DEPTH)+1-bit pointers with wrap bit. Full = (low bits equal, wrap bits differ). Empty = pointers equal.
- Output stage load condition: load = !flow_out_valid || flow_out_ready. A load occurs only when load is true and at least one FIFO is non-empty.
- Arbiter, evaluated in cycles where a load occurs:
  - only A non-empty -> grant A;
  - only B non-empty -> grant B;
  - both non-empty -> grant the one != last_grant;
  - the granted FIFO pops, and last_grant updates only on a grant.
- Load action on the edge:
  - flow_out <= head of the granted FIFO;
  - flow_out_src <= granted id;
  - flow_out_valid <= 1.
- If the output is accepted (valid && ready) with no load candidate: flow_out_valid <= 0. flow_out and flow_out_src hold their last value.
- Stall: while flow_out_valid && !flow_out_ready, flow_out and flow_out_src are stable and no FIFO pops.
- Latency: a word accepted at edge N appears with flow_out_valid high in the cycle after edge N+1, given an idle output and no contention. With ready held high, sustained throughput is 1 word/cycle.
- Ordering: per-source order is preserved. With both sources continuously non-empty and ready high, output alternates strictly.
- merge_count increments by 1 on every output transfer and wraps at 2^CNT_WIDTH to 0.
- Reset mid-operation: all buffered and in-flight words are discarded. Outputs return to reset values immediately on rst_n falling.

Test Plan:
- Reset then A only: A sends 0x11, 0x22, 0x33 back-to-back, ready=1 -> out 0x11, 0x22, 0x33 with src=0. First word valid 2 cycles after acceptance. merge_count = 3.
- Contention: both FIFOs preloaded with A 0xA0..0xA3 and B 0xB0..0xB3, ready=1 -> out 0xA0, 0xB0, 0xA1, 0xB1, 0xA2, 0xB2, 0xA3, 0xB3. src toggles 0,1,0,1...
- Backpressure: ready=0 for 10 cycles while A sends 6 words (DEPTH=4) ->
  - flow_in_a_ready drops after 4 FIFO words plus 1 held output;
  - flow_out stays frozen at the first word;
  - after ready=1, all 5 accepted words emerge in order with no loss or duplicates.
- Full-FIFO pop: FIFO A full, ready rises -> flow_in_a_ready low in that cycle, high the next cycle. A valid held by the sender is accepted one cycle later.
- Counter wrap (CNT_WIDTH=4): 17 output transfers -> merge_count sequence 0..15, 0, 1.
- Reset mid-stream: assert rst_n=0 with 3 words buffered and out valid -> flow_out_valid = 0 immediately. After release, no stale word appears and merge_count = 0.
